l15_req_arbiter: RTL

- Shares the single L1.5 request channel among NReq requesters: I$ miss, D$ miss-read, D$ write-buffer, D$ uncached read, D$ uncached write.
- Round-robin arbitration with one-entry request staging.
- Tracks outstanding transactions per requester, caps them, and reports drain status for fences.
- Sits between the I$/HPDcache request ports and the L1.5 packer inside the core tile's L1.5 adapter.

---
 rtl/l15_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/l15_req_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/l15_arb_pkg.sv
// Shared definitions for the L1.5 request arbiter: requester ids and stage states.
package l15_arb_pkg;

    localparam int NREQ = 5;

    typedef logic [$clog2(NREQ)-1:0] req_portid_t;

    localparam req_portid_t PID_ICACHE = req_portid_t'(0);
    localparam req_portid_t PID_DMISS  = req_portid_t'(1);
    localparam req_portid_t PID_WBUF   = req_portid_t'(2);
    localparam req_portid_t PID_UCRD   = req_portid_t'(3);
    localparam req_portid_t PID_UCWR   = req_portid_t'(4);

    // Staging register is either empty or holding a request offered to L1.5.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } stage_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after the pointer.
module rr_arbiter #(
    parameter int N    = 5,
    parameter int IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] gnt_idx_o,
    output logic            gnt_valid_o
);

    int unsigned cand_s;

    // Scan requesters starting at the pointer, wrapping, and take the first hit.
    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        cand_s      = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand_s = (int'(ptr_i) + i) % N;
            if (!gnt_valid_o && req_i[cand_s]) begin
                gnt_o[cand_s] = 1'b1;
                gnt_idx_o     = IdxW'(cand_s);
                gnt_valid_o   = 1'b1;
            end else begin
                gnt_valid_o   = gnt_valid_o;
            end
        end
    end

endmodule

// File: rtl/l15_req_arbiter.sv
// Shares the L1.5 request channel among the I$/D$ requesters with one-entry
// staging, round-robin fairness and per-requester outstanding caps.
module l15_req_arbiter
    import l15_arb_pkg::*;
#(
    parameter int NReq           = NREQ,
    parameter int PayloadWidth   = 128,
    parameter int MaxOutstanding = 4,
    parameter int CntWidth       = $clog2(MaxOutstanding + 1),
    localparam int PidWidth      = $clog2(NReq)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NReq-1:0]              req_valid_i,
    output logic [NReq-1:0]              req_ready_o,
    input  logic [NReq*PayloadWidth-1:0] req_payload_i,
    input  logic [NReq-1:0]              rsp_done_i,
    input  logic                         inhibit_i,
    output logic                         l15_val_o,
    output logic [PayloadWidth-1:0]      l15_payload_o,
    output logic [PidWidth-1:0]          l15_pid_o,
    input  logic                         l15_header_ack_i,
    output logic                         drained_o,
    output logic                         err_o
);

    stage_state_e                       state_r, state_next_s;
    logic [PidWidth-1:0]                ptr_r;
    logic [NReq-1:0][CntWidth-1:0]      cnt_r, cnt_next_s;
    logic [PayloadWidth-1:0]            payload_r;
    logic [PidWidth-1:0]                pid_r;
    logic                               err_r;
    logic                               err_hit_s;
    logic [NReq-1:0]                    elig_s;
    logic [NReq-1:0]                    gnt_oh_s;
    logic [PidWidth-1:0]                gnt_idx_s;
    logic                               gnt_any_s;
    logic                               grant_fire_s;

    // A requester may be picked only if it is below its in-flight cap and no fence blocks grants.
    always_comb begin
        elig_s = '0;
        for (int k = 0; k < NReq; k++) begin
            elig_s[k] = req_valid_i[k] & (cnt_r[k] < CntWidth'(MaxOutstanding)) & ~inhibit_i;
        end
    end

    rr_arbiter #(
        .N    (NReq),
        .IdxW (PidWidth)
    ) u_rr (
        .req_i       (elig_s),
        .ptr_i       (ptr_r),
        .gnt_o       (gnt_oh_s),
        .gnt_idx_o   (gnt_idx_s),
        .gnt_valid_o (gnt_any_s)
    );

    // Stage can take a new request when empty or when its current one is leaving this cycle.
    always_comb begin
        grant_fire_s = gnt_any_s & ((state_r == ST_IDLE) | l15_header_ack_i);
        if (grant_fire_s) begin
            req_ready_o = gnt_oh_s;
        end else begin
            req_ready_o = '0;
        end
    end

    // Staging FSM: fill on grant, empty on ack unless refilled back-to-back.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_fire_s) state_next_s = ST_SEND;
                else              state_next_s = ST_IDLE;
            end
            ST_SEND: begin
                if (l15_header_ack_i && !grant_fire_s) state_next_s = ST_IDLE;
                else                                   state_next_s = ST_SEND;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Per-requester in-flight counts; a done with nothing outstanding is flagged, not counted.
    always_comb begin
        cnt_next_s = cnt_r;
        err_hit_s  = 1'b0;
        for (int k = 0; k < NReq; k++) begin
            if (req_ready_o[k] && !rsp_done_i[k]) begin
                if (cnt_r[k] < CntWidth'(MaxOutstanding)) cnt_next_s[k] = cnt_r[k] + CntWidth'(1);
                else                                      cnt_next_s[k] = cnt_r[k];
            end else if (rsp_done_i[k] && !req_ready_o[k]) begin
                if (cnt_r[k] == CntWidth'(0)) err_hit_s     = 1'b1;
                else                          cnt_next_s[k] = cnt_r[k] - CntWidth'(1);
            end else begin
                cnt_next_s[k] = cnt_r[k];
            end
        end
    end

    // State, stage contents, RR pointer, counters and sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            ptr_r     <= '0;
            cnt_r     <= '0;
            payload_r <= '0;
            pid_r     <= '0;
            err_r     <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            err_r   <= err_r | err_hit_s;
            if (grant_fire_s) begin
                payload_r <= req_payload_i[int'(gnt_idx_s)*PayloadWidth +: PayloadWidth];
                pid_r     <= gnt_idx_s;
                ptr_r     <= (gnt_idx_s == PidWidth'(NReq - 1)) ? '0 : gnt_idx_s + PidWidth'(1);
            end
        end
    end

    assign l15_val_o     = (state_r == ST_SEND);
    assign l15_payload_o = payload_r;
    assign l15_pid_o     = pid_r;
    assign err_o         = err_r;
    assign drained_o     = (state_r == ST_IDLE) & (cnt_r == '0);

endmodule
